// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the execute-stage control logic and the HI/LO multiply/divide unit.
interface mul_div_unit_if;
    logic        start;
    logic [5:0]  fncode;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    modport master (output start, fncode, a, b, input hi, lo, busy, done);
    modport slave  (input start, fncode, a, b, output hi, lo, busy, done);
endinterface

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit: 32-step shift-add multiply, 32-step restoring divide,
// one sign-fix cycle, plus single-cycle MTHI/MTLO writes. Owns the HI and LO registers.
module mul_div_unit (
    input  logic           clk,
    input  logic           reset,
    mul_div_unit_if.slave  bus
);
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;
    logic        neg_lo_q, neg_lo_d;
    logic        neg_hi_q, neg_hi_d;
    logic        is_div_q, is_div_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        op_signed;
    logic [31:0] abs_a, abs_b;
    logic [32:0] sum, shifted, diff;
    logic [63:0] prod;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.fncode == FUNCT_MULT || bus.fncode == FUNCT_MULTU) state_d = S_MUL;
                    else if (bus.fncode == FUNCT_DIV || bus.fncode == FUNCT_DIVU) state_d = S_DIV;
                end
            end
            S_MUL, S_DIV: if (cnt_q == 5'd31) state_d = S_FIX;
            default:      state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        op_signed = (bus.fncode == FUNCT_MULT) || (bus.fncode == FUNCT_DIV);
        abs_a     = (op_signed && bus.a[31]) ? -bus.a : bus.a;
        abs_b     = (op_signed && bus.b[31]) ? -bus.b : bus.b;
        sum       = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        shifted   = {acc_q[63:32], acc_q[31]};
        diff      = shifted - {1'b0, opnd_q};
        prod      = neg_lo_q ? -acc_q : acc_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    case (bus.fncode)
                        FUNCT_MTHI: hi_d = bus.a;
                        FUNCT_MTLO: lo_d = bus.a;
                        FUNCT_MULT, FUNCT_MULTU: begin
                            acc_d    = {32'd0, abs_b};
                            opnd_d   = abs_a;
                            neg_lo_d = op_signed && (bus.a[31] ^ bus.b[31]);
                            neg_hi_d = 1'b0;
                            is_div_d = 1'b0;
                            cnt_d    = '0;
                        end
                        FUNCT_DIV, FUNCT_DIVU: begin
                            acc_d    = {32'd0, abs_a};
                            opnd_d   = abs_b;
                            // With a zero divisor the restoring loop yields all-ones quotient and
                            // remainder |a|; suppressing the quotient negate leaves lo=FFFFFFFF, hi=a.
                            neg_lo_d = op_signed && (bus.a[31] ^ bus.b[31]) && (bus.b != 32'd0);
                            neg_hi_d = op_signed && bus.a[31];
                            is_div_d = 1'b1;
                            cnt_d    = '0;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                acc_d = {sum, acc_q[31:1]};
                cnt_d = cnt_q + 5'd1;
            end
            S_DIV: begin
                if (!diff[32]) acc_d = {diff[31:0], acc_q[30:0], 1'b1};
                else           acc_d = {shifted[31:0], acc_q[30:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
            end
            default: begin
                if (is_div_q) begin
                    lo_d = neg_lo_q ? -acc_q[31:0]  : acc_q[31:0];
                    hi_d = neg_hi_q ? -acc_q[63:32] : acc_q[63:32];
                end else begin
                    {hi_d, lo_d} = prod;
                end
                done_d = 1'b1;
                cnt_d  = '0;
            end
        endcase
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized scoreboard bench for mul_div_unit against a plain-arithmetic HI/LO reference model.
module tb_mul_div_unit;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic clk = 1'b0;
    logic reset;
    mul_div_unit_if bus();

    mul_div_unit dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;
    logic        prev_done = 1'b0;
    logic [31:0] model_hi, model_lo;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model: architectural effect of one accepted operation on HI/LO.
    task automatic model_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        int     ia, ib;
        case (fn)
            F_MTHI: model_hi = a;
            F_MTLO: model_lo = a;
            F_MULTU: {model_hi, model_lo} = {32'd0, a} * {32'd0, b};
            F_MULT: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = sa * sb;
                {model_hi, model_lo} = p;
            end
            F_DIVU: begin
                if (b == 0) begin model_lo = 32'hFFFF_FFFF; model_hi = a; end
                else begin model_lo = a / b; model_hi = a % b; end
            end
            F_DIV: begin
                ia = $signed(a);
                ib = $signed(b);
                if (b == 0) begin model_lo = 32'hFFFF_FFFF; model_hi = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    model_lo = 32'h8000_0000; model_hi = 32'd0;
                end else begin
                    model_lo = ia / ib; model_hi = ia % ib;
                end
            end
            default: ;
        endcase
    endtask

    task automatic drive_start(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.fncode = fn;
        bus.a      = a;
        bus.b      = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic mt_op(input logic [5:0] fn, input logic [31:0] a);
        model_op(fn, a, 32'd0);
        drive_start(fn, a, 32'd0);
        @(negedge clk);
        check("mt_hi", {32'd0, bus.hi}, {32'd0, model_hi});
        check("mt_lo", {32'd0, bus.lo}, {32'd0, model_lo});
        check("mt_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
    endtask

    // Iterative op; intf>0 injects an MTLO request during cycle T+intf, which must be ignored.
    task automatic run_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b, input int intf);
        logic [31:0] old_hi, old_lo;
        int busy_cnt, lat;
        bit hold_ok;
        old_hi = model_hi;
        old_lo = model_lo;
        model_op(fn, a, b);
        exp_q.push_back({model_hi, model_lo});
        drive_start(fn, a, b);
        busy_cnt = 0; lat = 0; hold_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == intf + 1) bus.start = 1'b0;
            if (bus.busy) begin
                busy_cnt++;
                if (bus.hi !== old_hi || bus.lo !== old_lo) hold_ok = 1'b0;
            end
            if (bus.done) begin lat = k; break; end
            if (k == intf) begin
                bus.start = 1'b1; bus.fncode = F_MTLO; bus.a = 32'h0000_AAAA;
            end
        end
        bus.start = 1'b0;
        check("latency", 64'(lat), 64'd34);
        check("busy_cycles", 64'(busy_cnt), 64'd33);
        check("hold_while_busy", {63'd0, hold_ok}, 64'd1);
        $display("op fn=%h a=%h b=%h -> exp hi=%h lo=%h lat=%0d", fn, a, b, model_hi, model_lo, lat);
    endtask

    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", bus.hi, bus.lo);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", {bus.hi, bus.lo}, mon_exp);
            end
            check("done_one_cycle", {63'd0, prev_done}, 64'd0);
        end
        prev_done = bus.done;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] corner [5];
        logic [5:0]  fns [6];
        logic [31:0] ra, rb;
        logic [5:0]  rf;
        corner = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        fns    = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO};

        reset = 1'b1;
        bus.start = 1'b0; bus.fncode = '0; bus.a = '0; bus.b = '0;
        model_hi = '0; model_lo = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        check("reset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
        reset = 1'b0;

        mt_op(F_MTHI, 32'hDEAD_BEEF);
        mt_op(F_MTLO, 32'h1234_5678);

        drive_start(6'h20, 32'h5555_5555, 32'h1);
        @(negedge clk);
        check("ignored_fncode", {bus.hi, bus.lo}, {model_hi, model_lo});
        check("ignored_busy", {63'd0, bus.busy}, 64'd0);

        run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(F_MULT,  32'hFFFF_FFF9, 32'd3, 0);
        run_op(F_DIV,   32'hFFFF_FFF9, 32'd2, 0);
        run_op(F_DIVU,  32'd100, 32'd7, 0);
        run_op(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(F_DIVU,  32'd5, 32'd0, 0);
        run_op(F_DIV,   32'hFFFF_FFF9, 32'd0, 0);
        run_op(F_MULTU, 32'd3, 32'd5, 10);
        check("interference_lo", {32'd0, bus.lo}, 64'h0F);

        // Mid-operation reset discards the divide.
        drive_start(F_DIVU, 32'd1000, 32'd7);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_hilo", {bus.hi, bus.lo}, 64'd0);
        check("midreset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
        reset = 1'b0;
        model_hi = '0; model_lo = '0;
        run_op(F_MULTU, 32'd2, 32'd3, 0);

        for (int i = 0; i < 40; i++) begin
            rf = fns[$urandom_range(0, 5)];
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 32'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 32'($urandom);
            if (rf == F_MTHI || rf == F_MTLO) mt_op(rf, ra);
            else run_op(rf, ra, rb, 0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
